// File: rtl/dcache_flush_unit_pkg.sv
// Shared types and dcache geometry for the dcache flush unit.
// Holds the flush FSM encoding and the write-back counter helper.
package dcache_flush_unit_pkg;

    localparam int unsigned DCACHE_NR_SETS = 256;
    localparam int unsigned DCACHE_NR_WAYS = 8;
    localparam int unsigned WB_CNT_W       = 16;

    typedef enum logic [2:0] {
        IDLE,
        TAG_REQ,
        TAG_RSP,
        WB_REQ,
        WB_WAIT,
        INV,
        ACK,
        HOLDOFF
    } flush_state_e;

    function automatic logic [WB_CNT_W-1:0] sat_inc(
        input logic [WB_CNT_W-1:0] v
    );
        return (&v) ? v : v + WB_CNT_W'(1);
    endfunction

endpackage

// File: rtl/dcache_flush_unit_if.sv
// Tag-read, write-back and invalidate channels between the flush unit
// and the dcache arbiters.
interface dcache_flush_unit_if #(
    parameter int unsigned NR_SETS = 256,
    parameter int unsigned NR_WAYS = 8
);
    localparam int unsigned IDX_W = $clog2(NR_SETS);

    logic               tag_req_o;
    logic               tag_gnt_i;
    logic [IDX_W-1:0]   tag_idx_o;
    logic [NR_WAYS-1:0] tag_valid_i;
    logic [NR_WAYS-1:0] tag_dirty_i;

    logic               wb_req_o;
    logic               wb_gnt_i;
    logic [IDX_W-1:0]   wb_idx_o;
    logic [NR_WAYS-1:0] wb_way_o;
    logic               wb_done_i;

    logic               inv_req_o;
    logic               inv_gnt_i;
    logic [IDX_W-1:0]   inv_idx_o;
    logic [NR_WAYS-1:0] inv_way_o;

    modport master (
        output tag_req_o, tag_idx_o,
        input  tag_gnt_i, tag_valid_i, tag_dirty_i,
        output wb_req_o, wb_idx_o, wb_way_o,
        input  wb_gnt_i, wb_done_i,
        output inv_req_o, inv_idx_o, inv_way_o,
        input  inv_gnt_i
    );

    modport slave (
        input  tag_req_o, tag_idx_o,
        output tag_gnt_i, tag_valid_i, tag_dirty_i,
        input  wb_req_o, wb_idx_o, wb_way_o,
        output wb_gnt_i, wb_done_i,
        input  inv_req_o, inv_idx_o, inv_way_o,
        output inv_gnt_i
    );

endinterface

// File: rtl/dcache_flush_unit_lzc.sv
// Lowest-one priority encoder: picks the lowest set bit as a one-hot way.
module dcache_flush_unit_lzc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic             empty_o
);

    // Two's complement isolates the lowest set bit.
    assign onehot_o = in_i & (~in_i + WIDTH'(1));
    assign empty_o  = ~|in_i;

endmodule

// File: rtl/dcache_flush_unit.sv
// Walks every dcache set, writes back valid+dirty lines, invalidates the
// set, and pulses a flush acknowledge once the whole cache is clean.
module dcache_flush_unit
    import dcache_flush_unit_pkg::*;
#(
    parameter int unsigned NR_SETS = DCACHE_NR_SETS,
    parameter int unsigned NR_WAYS = DCACHE_NR_WAYS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    output logic                flush_ack_o,
    output logic                busy_o,
    output logic [WB_CNT_W-1:0] wb_count_o,
    dcache_flush_unit_if.master bus
);

    localparam int unsigned IDX_W = $clog2(NR_SETS);

    flush_state_e        state_q, state_d;
    logic [IDX_W-1:0]    set_q, set_d;
    logic [NR_WAYS-1:0]  mask_q, mask_d;
    logic [WB_CNT_W-1:0] cnt_q, cnt_d;
    logic [NR_WAYS-1:0]  way_oh;
    logic                mask_empty;
    logic [NR_WAYS-1:0]  rsp_mask;

    dcache_flush_unit_lzc #(
        .WIDTH (NR_WAYS)
    ) i_lzc (
        .in_i     (mask_q),
        .onehot_o (way_oh),
        .empty_o  (mask_empty)
    );

    assign rsp_mask      = bus.tag_valid_i & bus.tag_dirty_i;
    assign bus.inv_way_o = '1;
    assign busy_o        = (state_q != IDLE);
    assign wb_count_o    = cnt_q;

    always_comb begin
        state_d       = state_q;
        set_d         = set_q;
        mask_d        = mask_q;
        cnt_d         = cnt_q;
        flush_ack_o   = 1'b0;
        bus.tag_req_o = 1'b0;
        bus.wb_req_o  = 1'b0;
        bus.inv_req_o = 1'b0;
        bus.wb_way_o  = '0;
        bus.tag_idx_o = set_q;
        bus.wb_idx_o  = set_q;
        bus.inv_idx_o = set_q;
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = TAG_REQ;
                    set_d   = '0;
                    cnt_d   = '0;
                end
            end
            TAG_REQ: begin
                bus.tag_req_o = 1'b1;
                if (bus.tag_gnt_i) state_d = TAG_RSP;
            end
            TAG_RSP: begin
                mask_d  = rsp_mask;
                state_d = (|rsp_mask) ? WB_REQ : INV;
            end
            WB_REQ: begin
                bus.wb_req_o = 1'b1;
                bus.wb_way_o = way_oh;
                if (bus.wb_gnt_i) begin
                    mask_d  = mask_q & ~way_oh;
                    cnt_d   = sat_inc(cnt_q);
                    state_d = WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (bus.wb_done_i) state_d = mask_empty ? INV : WB_REQ;
            end
            INV: begin
                bus.inv_req_o = 1'b1;
                if (bus.inv_gnt_i) begin
                    if (set_q == IDX_W'(NR_SETS - 1)) begin
                        state_d = ACK;
                    end else begin
                        set_d   = set_q + IDX_W'(1);
                        state_d = TAG_REQ;
                    end
                end
            end
            ACK: begin
                flush_ack_o = 1'b1;
                state_d     = HOLDOFF;
            end
            // Controller's registered request lingers one cycle past the ack.
            HOLDOFF: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            set_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Randomized bench for dcache_flush_unit against a per-set event model.
// A responder process plays the tag/write-back/invalidate arbiters.
module tb_dcache_flush_unit;

    localparam int S = 4;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ack;
    logic        busy;
    logic [15:0] wbcnt;

    dcache_flush_unit_if #(.NR_SETS(S), .NR_WAYS(W)) bus ();

    dcache_flush_unit #(
        .NR_SETS (S),
        .NR_WAYS (W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .flush_ack_o (ack),
        .busy_o      (busy),
        .wb_count_o  (wbcnt),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [W-1:0] vld [S];
    logic [W-1:0] drt [S];
    logic [17:0]  evlog [$];
    logic [17:0]  expq [$];
    int gmode = 0;
    int done_dly = 1;
    int excl_err = 0;
    int stab_err = 0;
    int way_err = 0;

    // Expected event stream: per set a tag read, one write-back per
    // valid+dirty way in ascending order, then the invalidate.
    function automatic int build_exp();
        int nwb = 0;
        logic [W-1:0] m;
        expq.delete();
        for (int s = 0; s < S; s++) begin
            expq.push_back({2'd1, 8'(s), 8'h00});
            m = vld[s] & drt[s];
            for (int w = 0; w < W; w++) begin
                if (m[w]) begin
                    expq.push_back({2'd2, 8'(s), 8'(1 << w)});
                    nwb++;
                end
            end
            expq.push_back({2'd3, 8'(s), 8'hFF});
        end
        return nwb;
    endfunction

    initial begin : responder
        bit tag_hs, tp, wp, ip;
        int hs_idx, dcnt, tw, iw;
        logic [7:0] ti, wi, ii;
        logic [W-1:0] ww;
        tag_hs = 0; tp = 0; wp = 0; ip = 0;
        hs_idx = 0; dcnt = 0; tw = 0; iw = 0;
        ti = 0; wi = 0; ii = 0; ww = 0;
        bus.tag_gnt_i = 0; bus.wb_gnt_i = 0; bus.inv_gnt_i = 0;
        bus.wb_done_i = 0; bus.tag_valid_i = 0; bus.tag_dirty_i = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tag_hs = 0; dcnt = 0; tw = 0; iw = 0;
                tp = 0; wp = 0; ip = 0;
                bus.tag_gnt_i = 0; bus.wb_gnt_i = 0;
                bus.inv_gnt_i = 0; bus.wb_done_i = 0;
                continue;
            end
            if (tag_hs) begin
                bus.tag_valid_i = vld[hs_idx];
                bus.tag_dirty_i = drt[hs_idx];
            end else begin
                bus.tag_valid_i = W'($urandom);
                bus.tag_dirty_i = W'($urandom);
            end
            bus.wb_done_i = 0;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) bus.wb_done_i = 1;
            end
            if ($countones({bus.tag_req_o, bus.wb_req_o, bus.inv_req_o}) > 1)
                excl_err++;
            if (bus.inv_way_o !== '1) way_err++;
            if (bus.wb_req_o && !$onehot(bus.wb_way_o)) way_err++;
            if (tp && (!bus.tag_req_o || 8'(bus.tag_idx_o) != ti)) stab_err++;
            if (wp && (!bus.wb_req_o || 8'(bus.wb_idx_o) != wi ||
                       bus.wb_way_o != ww)) stab_err++;
            if (ip && (!bus.inv_req_o || 8'(bus.inv_idx_o) != ii)) stab_err++;
            if (gmode == 0) begin
                bus.tag_gnt_i = 1; bus.wb_gnt_i = 1; bus.inv_gnt_i = 1;
            end else if (gmode == 1) begin
                bus.tag_gnt_i = ($urandom_range(0, 99) < 50);
                bus.wb_gnt_i  = ($urandom_range(0, 99) < 50);
                bus.inv_gnt_i = ($urandom_range(0, 99) < 50);
            end else begin
                tw = bus.tag_req_o ? tw + 1 : 0;
                iw = bus.inv_req_o ? iw + 1 : 0;
                bus.tag_gnt_i = (tw > 5);
                bus.inv_gnt_i = (iw > 5);
                bus.wb_gnt_i  = 1;
                if (tw > 5) tw = 0;
                if (iw > 5) iw = 0;
            end
            tag_hs = bus.tag_req_o && bus.tag_gnt_i;
            hs_idx = int'(bus.tag_idx_o);
            if (tag_hs) evlog.push_back({2'd1, 8'(bus.tag_idx_o), 8'h00});
            if (bus.wb_req_o && bus.wb_gnt_i) begin
                evlog.push_back({2'd2, 8'(bus.wb_idx_o), 8'(bus.wb_way_o)});
                dcnt = (done_dly == 0) ? $urandom_range(1, 4) : done_dly;
            end
            if (bus.inv_req_o && bus.inv_gnt_i)
                evlog.push_back({2'd3, 8'(bus.inv_idx_o), 8'(bus.inv_way_o)});
            tp = bus.tag_req_o && !bus.tag_gnt_i; ti = 8'(bus.tag_idx_o);
            wp = bus.wb_req_o && !bus.wb_gnt_i;   wi = 8'(bus.wb_idx_o);
            ww = bus.wb_way_o;
            ip = bus.inv_req_o && !bus.inv_gnt_i; ii = 8'(bus.inv_idx_o);
        end
    end

    task automatic run_flush(input string name, input bit hold,
                             input int per_set, input int per_line);
        int n, lat, acks, nwb, m;
        logic b2, b3;
        nwb = build_exp();
        evlog.delete();
        @(negedge clk);
        flush = 1;
        n = 0; lat = 0; acks = 0; b2 = 1; b3 = 1;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (ack) begin
                acks++;
                if (acks == 1) lat = n;
            end
            if (!hold && n == 1) flush = 0;
            if (hold && acks > 0 && n == lat + 1) flush = 0;
            if (acks > 0 && n == lat + 2) b2 = busy;
            if (acks > 0 && n == lat + 3) begin
                b3 = busy;
                break;
            end
        end
        flush = 0;
        check({name, "/acks"}, acks, 1);
        if (per_set > 0)
            check({name, "/lat"}, lat, S * per_set + 1 + nwb * per_line);
        check({name, "/wbcnt"}, wbcnt, nwb);
        check({name, "/idle"}, {b2, b3}, 0);
        check({name, "/nev"}, evlog.size(), expq.size());
        m = (evlog.size() < expq.size()) ? evlog.size() : expq.size();
        for (int i = 0; i < m; i++)
            check($sformatf("%s/ev%0d", name, i), evlog[i], expq[i]);
    endtask

    initial begin : main
        int n, acks;
        bit found;
        for (int s = 0; s < S; s++) begin
            vld[s] = '0;
            drt[s] = '0;
        end
        repeat (2) @(negedge clk);
        check("rst/outs", {ack, busy, bus.tag_req_o, bus.wb_req_o,
                           bus.inv_req_o}, 0);
        check("rst/wbcnt", wbcnt, 0);
        check("rst/invway", bus.inv_way_o, 8'hFF);
        check("rst/idx", {bus.tag_idx_o, bus.wb_idx_o, bus.inv_idx_o,
                          bus.wb_way_o}, 0);
        #2 rst_n = 1;

        gmode = 0; done_dly = 1;
        run_flush("clean", 0, 3, 2);

        vld[2] = 8'h22; drt[2] = 8'h22;
        vld[0] = 8'h10; drt[0] = 8'h08;
        done_dly = 3;
        run_flush("dirty", 1, 3, 4);

        gmode = 2; done_dly = 1;
        vld[2] = '0; drt[2] = '0;
        vld[1] = 8'h80; drt[1] = 8'hFF;
        run_flush("hold5", 0, 13, 2);

        gmode = 0; done_dly = 4;
        for (int s = 0; s < S; s++) begin
            vld[s] = '0;
            drt[s] = '0;
        end
        vld[1] = 8'h0C; drt[1] = 8'h0C;
        @(negedge clk); flush = 1;
        @(negedge clk); flush = 0;
        n = 0; found = 0;
        while (n < 100 && !found) begin
            @(negedge clk);
            n++;
            found = bus.wb_req_o;
        end
        check("rst/reach_wb", found, 1);
        @(negedge clk);
        #2 rst_n = 0;
        #1 check("rst/drop", {ack, busy, bus.tag_req_o, bus.wb_req_o,
                              bus.inv_req_o}, 0);
        check("rst/wbcnt2", wbcnt, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack) acks++;
        end
        check("rst/no_ack", acks, 0);
        check("rst/busy", busy, 0);
        run_flush("fresh", 0, 3, 5);

        gmode = 1; done_dly = 0;
        for (int it = 0; it < 6; it++) begin
            for (int s = 0; s < S; s++) begin
                vld[s] = W'($urandom);
                drt[s] = W'($urandom);
            end
            run_flush($sformatf("rnd%0d", it), it[0], 0, 0);
        end

        check("excl", excl_err, 0);
        check("stable", stab_err, 0);
        check("way", way_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
